pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Hazard and stall controller for the five-stage pipeline. Compares pre-decoded register-use and register-write fields from the D, E and M stages. Tracks the multi-cycle mult/div unit through an internal busy counter. Drives the freeze and bubble controls for the PC, the F/D register and the D/E register, and keeps a stall-cycle performance counter.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, width of the mult/div countdown (must hold DIV_CYCLES)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
rs_D  in  5  rs field of D-stage instruction
rt_D  in  5  rt field of D-stage instruction
tuse_rs_D  in  2  cycles until rs is needed (0..2); 3 = rs not read
tuse_rt_D  in  2  cycles until rt is needed (0..2); 3 = rt not read
md_D  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
wa_E  in  5  destination register of E-stage instr (0 = none)
tnew_E  in  2  cycles until E result is ready (0..2)
md_start_E  in  1  E instr is a mult/div start (one cycle per instr)
md_div_E  in  1  qualifies md_start_E: 1 = div/divu, 0 = mult/multu
wa_M  in  5  destination register of M-stage instr (0 = none)
tnew_M  in  2  cycles until M result is ready (0..1)
stall  out  1  hazard present this cycle
en_PC  out  1  PC write enable (= ~stall)
en_FD  out  1  F/D register write enable (= ~stall)
flush_E  out  1  load a bubble (IR=0) into the D/E register (= stall)
md_busy  out  1  mult/div unit busy
stall_cnt  out  32  total stall cycles since reset

Behaviour:
- Reset (async, active-high): countdown=0, md_busy=0, stall_cnt=0. With all inputs zero: stall=0, en_PC=1, en_FD=1, flush_E=0.
- Register hazard (combinational): stall_rs = (rs_D!=0) && (tuse_rs_D!=3) && ((rs_D==wa_E && tuse_rs_D<tnew_E) || (rs_D==wa_M && tuse_rs_D<tnew_M)). stall_rt is the same form using rt.
- Register 0 never causes a stall. tuse=3 never stalls. tnew=0 never stalls; the forwarding path covers it.
- M/D hazard: stall_md = md_D && (md_busy || md_start_E).
- stall = stall_rs | stall_rt | stall_md. Purely combinational from inputs and registered state, so it is valid in the same cycle.
- Countdown: on a rising edge with md_start_E=1 and countdown==0, load DIV_CYCLES if md_div_E, else MULT_CYCLES.
- Otherwise, if countdown!=0, decrement by 1 each edge.
- md_busy = (countdown!=0), registered-derived. It rises the cycle after the start cycle and stays high for exactly N cycles.
- md_start_E while countdown!=0 is illegal: the stall prevents it. If it occurs, ignore it, keep counting, and raise a simulation assertion.
- stall_cnt increments on each rising edge where stall=1. It wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-operation clears the countdown immediately; md_busy drops without waiting for a clock.
- Simultaneous register and md hazards: a single stall, and stall_cnt increments by 1.

Decomposition:
- Shared constants package (const.v): TUSE_NONE=2'd3; Tnew/Tuse encodings; MULT_CYCLES/DIV_CYCLES defaults; bubble IR value 32'h0.
- Sub-module md_busy_counter:
  - Inputs: clk, reset, start, is_div.
  - Output: busy.
  - Contents: the countdown plus parameters.
- Hazard compare stays in the top module.

Test Plan:
- Reset: assert reset with random inputs, release -> md_busy=0, stall_cnt=0; inputs zero -> stall=0, en_PC=1.
- Load-use: wa_E=8, tnew_E=2, rs_D=8, tuse_rs_D=1 -> stall=1, flush_E=1, en_FD=0. Next cycle present wa_M=8, tnew_M=1, tuse_rs_D=1 -> stall=0.
- Zero register: wa_E=0, tnew_E=2, rs_D=0, tuse_rs_D=0 -> stall=0. Then tuse_rs_D=3, rs_D=wa_E=5 -> stall=0.
- Mult busy:
  - md_start_E=1, md_div_E=0 for one cycle -> md_busy=1 for exactly 5 cycles, then 0.
  - md_D=1 throughout -> stall high for the start cycle + 5 cycles; stall_cnt=6.
- Div with reset: start a div; after 4 busy cycles assert reset asynchronously -> md_busy=0 before the next edge, stall_cnt=0.
- Combined hazards: md_busy=1 and rt hazard (rt_D=wa_E=9, tuse_rt_D=0, tnew_E=1) in the same cycle -> stall=1, stall_cnt +1 only. Also preload stall_cnt near 0xFFFFFFFF via force -> wraps to 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//   Shared definitions for the five-stage pipeline stall controller.
//   - Tuse "not read" encoding and the default mult/div busy lengths.
//   - hazard_t groups the individual stall causes so the top can OR them.
//   - reg_hazard() is the per-source-operand register hazard test.
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    // Tuse value meaning "this operand is not read by the D instruction".
    // Tuse 0..2 and Tnew 0..2 are plain cycle counts.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default busy lengths of the mult/div unit after a start.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Individual stall causes; any set bit freezes the front end.
    typedef struct packed {
        logic rs;
        logic rt;
        logic md;
    } hazard_t;

    // A source operand must wait when a younger-than-forwardable producer in
    // E or M targets it: the value is needed (tuse) before it exists (tnew).
    // Register 0 is hard-wired, and tnew==0 is always covered by forwarding
    // (tuse < 0 can never hold).
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((src == wa_e) && (tuse < tnew_e)) ||
                ((src == wa_m) && (tuse < tnew_m)));
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_counter.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_md_busy_counter
//   Countdown model of the multi-cycle mult/div unit. A start with the
//   counter idle loads DIV_CYCLES or MULT_CYCLES; the counter then decrements
//   once per clock. busy is high while the count is non-zero, i.e. for
//   exactly N cycles starting the cycle after the start.
//
//   Ports:
//     clk     in   pipeline clock, rising edge
//     reset   in   asynchronous, active-high reset (clears the count)
//     start   in   E-stage mult/div start (one cycle per instruction)
//     is_div  in   qualifies start: 1 = div/divu, 0 = mult/multu
//     busy    out  unit busy (count != 0)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl_md_busy_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] r_count;
    logic             w_busy;

    assign w_busy = (r_count != '0);
    assign busy   = w_busy;

    // A start arriving while already busy is ignored; the running operation
    // keeps counting down undisturbed.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (start && !w_busy) begin
            r_count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (w_busy) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // The front-end stall must keep a second mult/div out of E while busy.
    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (reset) !(start && w_busy)
    );

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Hazard and stall controller for the five-stage pipeline. Compares the
//   pre-decoded register-use fields of the D instruction against the
//   register-write fields of E and M, and blocks mult/div-family
//   instructions in D while the mult/div unit is busy or starting.
//   A stall freezes PC and F/D and loads a bubble into D/E. A free-running
//   counter records the number of stalled cycles.
//
//   Ports:
//     clk, reset               clock (rising) / async active-high reset
//     rs_D, rt_D               D-stage source registers
//     tuse_rs_D, tuse_rt_D     cycles until operand needed (3 = not read)
//     md_D                     D instr belongs to the mult/div family
//     wa_E, tnew_E             E-stage destination (0 = none) / cycles to ready
//     md_start_E, md_div_E     E-stage mult/div start and its div qualifier
//     wa_M, tnew_M             M-stage destination (0 = none) / cycles to ready
//     stall                    hazard present this cycle (combinational)
//     en_PC, en_FD             PC and F/D write enables (= ~stall)
//     flush_E                  bubble into D/E (= stall)
//     md_busy                  mult/div unit busy
//     stall_cnt                stall cycles since reset (wraps)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_D,
    input  logic [4:0]  wa_E,
    input  logic [1:0]  tnew_E,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic [4:0]  wa_M,
    input  logic [1:0]  tnew_M,
    output logic        stall,
    output logic        en_PC,
    output logic        en_FD,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    hazard_t     w_haz;
    logic        w_stall;
    logic        w_md_busy;
    logic [31:0] r_stall_cnt;

    pipe_stall_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_div_E),
        .busy   (w_md_busy)
    );

    // The md hazard also covers the start cycle itself: the unit is not yet
    // busy, but the operation in E will be, so a mult/div-family D
    // instruction must not advance behind it.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned and infers a latch.
        w_haz    = '0;
        w_haz.rs = reg_hazard(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M);
        w_haz.rt = reg_hazard(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
        w_haz.md = md_D && (w_md_busy || md_start_E);
        w_stall  = |w_haz;
    end

    assign stall     = w_stall;
    assign en_PC     = ~w_stall;
    assign en_FD     = ~w_stall;
    assign flush_E   = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

    // Overlapping causes still count as a single stalled cycle; the counter
    // wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Directed bench for pipe_stall_ctrl: table of register-hazard vectors
//   plus hand-written multi-cycle sequences (mult busy window, async reset
//   during div, overlapping hazards, stall counter wrap).
//   Inputs change 1 ns after a rising edge; outputs are sampled on the
//   falling edge or 1 ns after a rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs_D, rt_D, wa_E, wa_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_D, md_start_E, md_div_E;
    logic        stall, en_PC, en_FD, flush_E, md_busy;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .wa_E       (wa_E),
        .tnew_E     (tnew_E),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .wa_M       (wa_M),
        .tnew_M     (tnew_M),
        .stall      (stall),
        .en_PC      (en_PC),
        .en_FD      (en_FD),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic [1:0] tuse_rt;
        logic [4:0] wa_e;
        logic [1:0] tnew_e;
        logic [4:0] wa_m;
        logic [1:0] tnew_m;
        logic       md;
        logic       exp_stall;
    } vec_t;

    localparam int N_VEC = 15;
    vec_t vecs [N_VEC];

    function automatic vec_t mk(
        input string name,
        input logic [4:0] rs, input logic [1:0] tuse_rs,
        input logic [4:0] rt, input logic [1:0] tuse_rt,
        input logic [4:0] wa_e, input logic [1:0] tnew_e,
        input logic [4:0] wa_m, input logic [1:0] tnew_m,
        input logic md, input logic exp_stall
    );
        vec_t v;
        v.name = name;   v.rs = rs;     v.tuse_rs = tuse_rs;
        v.rt = rt;       v.tuse_rt = tuse_rt;
        v.wa_e = wa_e;   v.tnew_e = tnew_e;
        v.wa_m = wa_m;   v.tnew_m = tnew_m;
        v.md = md;       v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stall and all three derived controls in one comparison.
    task automatic check_ctrl(input string name, input logic exp_s);
        check({name, " ctrl{stall,en_PC,en_FD,flush_E}"},
              {28'd0, stall, en_PC, en_FD, flush_E},
              {28'd0, exp_s, ~exp_s, ~exp_s, exp_s});
    endtask

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; md_D = 1'b0;
        wa_E = '0; tnew_E = '0; md_start_E = 1'b0; md_div_E = 1'b0;
        wa_M = '0; tnew_M = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        rs_D = v.rs;   tuse_rs_D = v.tuse_rs;
        rt_D = v.rt;   tuse_rt_D = v.tuse_rt;
        wa_E = v.wa_e; tnew_E = v.tnew_e;
        wa_M = v.wa_m; tnew_M = v.tnew_m;
        md_D = v.md;   md_start_E = 1'b0; md_div_E = 1'b0;
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after a later rising edge.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_cnt = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset with random inputs ----------------
        vecs[0]  = mk("idle",         5'd0, 2'd0, 5'd0, 2'd0, 5'd0,  2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk("load_use_E",   5'd8, 2'd1, 5'd0, 2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0, 1'b1);
        vecs[2]  = mk("fwd_from_M",   5'd8, 2'd1, 5'd0, 2'd3, 5'd0,  2'd0, 5'd8, 2'd1, 1'b0, 1'b0);
        vecs[3]  = mk("zero_reg",     5'd0, 2'd0, 5'd0, 2'd3, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[4]  = mk("tuse_none",    5'd5, 2'd3, 5'd0, 2'd3, 5'd5,  2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[5]  = mk("tnew_zero",    5'd5, 2'd0, 5'd0, 2'd3, 5'd5,  2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[6]  = mk("rt_E",         5'd0, 2'd3, 5'd9, 2'd0, 5'd9,  2'd1, 5'd0, 2'd0, 1'b0, 1'b1);
        vecs[7]  = mk("rt_M",         5'd0, 2'd3, 5'd9, 2'd0, 5'd0,  2'd0, 5'd9, 2'd1, 1'b0, 1'b1);
        vecs[8]  = mk("tuse_eq_tnew", 5'd7, 2'd2, 5'd0, 2'd3, 5'd7,  2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[9]  = mk("rs_M_not_E",   5'd7, 2'd0, 5'd0, 2'd3, 5'd3,  2'd2, 5'd7, 2'd1, 1'b0, 1'b1);
        vecs[10] = mk("no_match",     5'd4, 2'd0, 5'd0, 2'd3, 5'd6,  2'd2, 5'd6, 2'd1, 1'b0, 1'b0);
        vecs[11] = mk("md_idle",      5'd0, 2'd3, 5'd0, 2'd3, 5'd0,  2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        vecs[12] = mk("rt_r31",       5'd0, 2'd3, 5'd31, 2'd1, 5'd31, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1);
        vecs[13] = mk("rs_rt_both",   5'd10, 2'd0, 5'd10, 2'd0, 5'd10, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1);
        vecs[14] = mk("rt_zero_M",    5'd0, 2'd3, 5'd0, 2'd0, 5'd0,  2'd0, 5'd0, 2'd1, 1'b0, 1'b0);

        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rs_D = 5'($urandom); rt_D = 5'($urandom);
            tuse_rs_D = 2'($urandom); tuse_rt_D = 2'($urandom);
            md_D = 1'($urandom); wa_E = 5'($urandom); tnew_E = 2'($urandom);
            md_start_E = 1'($urandom); md_div_E = 1'($urandom);
            wa_M = 5'($urandom); tnew_M = 2'($urandom);
        end
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b0;
        exp_cnt = 32'd0;
        #4;
        check("reset md_busy", {31'd0, md_busy}, 32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);
        check_ctrl("reset", 1'b0);
        @(posedge clk); #1;

        // ---------------- register hazard table ----------------
        for (int i = 0; i < N_VEC; i++) begin
            drive_vec(vecs[i]);
            #4;
            check_ctrl(vecs[i].name, vecs[i].exp_stall);
            @(posedge clk); #1;
            if (vecs[i].exp_stall) exp_cnt = exp_cnt + 32'd1;
            check({vecs[i].name, " stall_cnt"}, stall_cnt, exp_cnt);
        end
        clear_inputs();

        // ---------------- mult busy window ----------------
        do_reset();
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b0;
        #4;
        check_ctrl("mult start cycle", 1'b1);
        check("mult start md_busy", {31'd0, md_busy}, 32'd0);
        @(posedge clk); #1;
        md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #4;
            check($sformatf("mult busy cycle %0d md_busy", i), {31'd0, md_busy}, 32'd1);
            check_ctrl($sformatf("mult busy cycle %0d", i), 1'b1);
            @(posedge clk); #1;
        end
        #4;
        check("mult done md_busy", {31'd0, md_busy}, 32'd0);
        check_ctrl("mult done", 1'b0);
        check("mult stall_cnt", stall_cnt, 32'd6);
        @(posedge clk); #1;
        clear_inputs();

        // ---------------- div interrupted by async reset ----------------
        do_reset();
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b1;
        #4;
        check_ctrl("div start cycle", 1'b1);
        @(posedge clk); #1;
        md_start_E = 1'b0; md_div_E = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            check($sformatf("div busy cycle %0d md_busy", i), {31'd0, md_busy}, 32'd1);
            @(posedge clk); #1;
        end
        check("div pre-reset md_busy", {31'd0, md_busy}, 32'd1);
        check("div pre-reset stall_cnt", stall_cnt, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("div async reset md_busy", {31'd0, md_busy}, 32'd0);
        check("div async reset stall_cnt", stall_cnt, 32'd0);
        check_ctrl("div async reset", 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 32'd0;
        #4;
        check("div after reset md_busy", {31'd0, md_busy}, 32'd0);
        @(posedge clk); #1;
        clear_inputs();

        // ---------------- md busy + rt hazard in the same cycle ----------------
        md_start_E = 1'b1; md_div_E = 1'b0;
        #4;
        check_ctrl("combo start (md_D=0)", 1'b0);
        @(posedge clk); #1;
        md_start_E = 1'b0;
        md_D = 1'b1; rt_D = 5'd9; tuse_rt_D = 2'd0; wa_E = 5'd9; tnew_E = 2'd1;
        #4;
        check("combo md_busy", {31'd0, md_busy}, 32'd1);
        check_ctrl("combo md+rt", 1'b1);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        check("combo stall_cnt +1", stall_cnt, exp_cnt);
        clear_inputs();
        begin
            int waited;
            waited = 0;
            while (md_busy && waited < 10) begin
                @(posedge clk); #1;
                waited++;
            end
            check("combo md_busy drains", {31'd0, md_busy}, 32'd0);
        end
        check("combo stall_cnt steady", stall_cnt, exp_cnt);

        // ---------------- stall counter wrap ----------------
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        drive_vec(vecs[1]);
        #3;
        check_ctrl("wrap hazard", 1'b1);
        @(posedge clk); #1;
        check("wrap to max", stall_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("wrap to zero", stall_cnt, 32'h0000_0000);
        clear_inputs();
        #4;
        check_ctrl("wrap idle", 1'b0);
        @(posedge clk); #1;
        check("wrap hold", stall_cnt, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
